// File: rtl/keypad_scanner_if.sv
// Key-event channel of the keypad scanner: valid/ready head of the event
// buffer plus the held and overrun status flags.
interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic       key_overrun;

    modport master (
        output key_valid,
        output key_code,
        output key_held,
        output key_overrun,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_held,
        input  key_overrun,
        output key_ready
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad column by column, debounces
// whole-scan results, and queues one key code per press in a 2-entry buffer.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat while a key is held.
module keypad_scanner #(
    parameter int SCAN_TICKS         = 100000,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 500,
    parameter int REPEAT_RATE_SCANS  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row_n,
    output logic [3:0]       col_n,
    keypad_scanner_if.master kif
);
    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_N     = DW'(DEBOUNCE_SCANS);

    generate
        if (SCAN_TICKS < 4 || DEBOUNCE_SCANS < 1 ||
            REPEAT_DELAY_SCANS < 1 || REPEAT_RATE_SCANS < 1) begin : g_param_check
            $error("keypad_scanner: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED} state_t;

    // Row-major keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]    sync1_q, sync2_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    seen_q, seen_d;     // presses seen this scan, saturating at 2
    logic [3:0]    scode_q, scode_d;   // code of the first press seen this scan
    logic [2:0]    hit_cnt;
    logic [1:0]    hit_row, seen_tot;
    logic [3:0]    code_tot, res_code;
    logic          dwell_last, scan_end, res_is_code;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DW-1:0] rcnt_q, rcnt_d, rcnt_inc;
    logic          emit_q, emit_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                             REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
    localparam int RW = $clog2(REP_MAX + 1);
    logic [RW-1:0] rep_q, rep_d, rep_inc;
    logic          armed_q, armed_d;   // first repeat already issued
`endif

    logic [3:0]    mem_q [2];
    logic          rd_q, wr_q, ovr_q;
    logic [1:0]    fcnt_q;
    logic          pop, full, push_ok;

    // Two-stage synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= row_n;
            sync2_q <= sync1_q;
        end
    end

    // Column dwell timing and per-scan accumulation of pressed keys
    always_comb begin
        hit_cnt = '0;
        hit_row = '0;
        for (int r = 0; r < 4; r++) begin
            if (!sync2_q[3-r]) begin
                hit_cnt = hit_cnt + 3'd1;
                hit_row = 2'(r);
            end
        end
        seen_tot = seen_q;
        code_tot = scode_q;
        if (hit_cnt >= 3'd2) begin
            seen_tot = 2'd2;
        end else if (hit_cnt == 3'd1) begin
            if (seen_q == 2'd0) begin
                seen_tot = 2'd1;
                code_tot = key_map(hit_row, col_q);
            end else begin
                seen_tot = 2'd2;
            end
        end
        dwell_last  = (tick_q == TICK_LAST);
        scan_end    = dwell_last && (col_q == 2'd3);
        res_is_code = scan_end && (seen_tot == 2'd1);   // MULTI falls out as "not a code"
        res_code    = code_tot;
        tick_d      = dwell_last ? '0 : tick_q + TW'(1);
        col_d       = dwell_last ? col_q + 2'd1 : col_q;
        seen_d      = seen_q;
        scode_d     = scode_q;
        if (dwell_last) begin
            seen_d  = scan_end ? 2'd0 : seen_tot;
            scode_d = code_tot;
        end
    end

    // Scan counters and accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q  <= '0;
            col_q   <= '0;
            seen_q  <= '0;
            scode_q <= '0;
        end else begin
            tick_q  <= tick_d;
            col_q   <= col_d;
            seen_q  <= seen_d;
            scode_q <= scode_d;
        end
    end

    assign col_n = ~(4'b1000 >> col_q);

    // Debounce FSM next state; steps only on the scan-end cycle
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        emit_d   = 1'b0;
        cnt_inc  = cnt_q + DW'(1);
        rcnt_inc = rcnt_q + DW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d    = rep_q;
        armed_d  = armed_q;
        rep_inc  = rep_q + RW'(1);
`endif
        if (scan_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (res_is_code) begin
                        cand_d = res_code;
                        cnt_d  = DW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = ST_PRESSED;
                            emit_d  = 1'b1;
                            rcnt_d  = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
                            armed_d = 1'b0;
`endif
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (res_is_code && res_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            state_d = ST_PRESSED;
                            emit_d  = 1'b1;
                            rcnt_d  = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
                            armed_d = 1'b0;
`endif
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    // A different code only keeps the key "down"; it never emits
                    rcnt_d = res_is_code ? '0 : rcnt_inc;
                    if (!res_is_code && rcnt_inc == DEB_N) begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                        cnt_d   = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if ((!armed_q && rep_inc == RW'(REPEAT_DELAY_SCANS)) ||
                             ( armed_q && rep_inc == RW'(REPEAT_RATE_SCANS))) begin
                        emit_d  = 1'b1;
                        rep_d   = '0;
                        armed_d = 1'b1;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            emit_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
            armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            emit_q  <= emit_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
            armed_q <= armed_d;
`endif
        end
    end

    // A pop frees a slot before the push is judged, so full+pop+push is accepted
    assign pop     = (fcnt_q != 2'd0) && kif.key_ready;
    assign full    = (fcnt_q == 2'd2);
    assign push_ok = emit_q && (!full || pop);

    // Two-entry event buffer; emitted code is cand_q, stable for a whole scan
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            fcnt_q   <= '0;
            ovr_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= cand_q;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            fcnt_q <= fcnt_q + {1'b0, push_ok} - {1'b0, pop};
            ovr_q  <= emit_q && full && !pop;
        end
    end

    assign kif.key_valid   = (fcnt_q != 2'd0);
    assign kif.key_code    = mem_q[rd_q];
    assign kif.key_held    = (state_q == ST_PRESSED);
    assign kif.key_overrun = ovr_q;
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Drives the column strobes of the 4x4 Pmod keypad on JB and samples its row lines. Debounces the samples and emits one 4-bit key event per press through a 2-deep valid/ready buffer. Sits between the JB pins and the calculator control FSM, and replaces ad-hoc scanning inside the top level. Its pin behaviour matches the keypad model in the board testbench: columns are driven, rows are read, and both are active-low.

Parameters:
SCAN_TICKS, 100000, clk cycles each column is held low (1 ms at 100 MHz); minimum 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1
REPEAT_DELAY_SCANS, 500, scans held before the first auto-repeat (KEYPAD_AUTOREPEAT_EN only)
REPEAT_RATE_SCANS, 100, scans between later auto-repeats (KEYPAD_AUTOREPEAT_EN only)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
row_n  in  4  keypad rows (JB[7:4]); row r pressed when row_n[3-r]=0
col_n  out  4  keypad columns (JB[3:0]); column c strobed when col_n[3-c]=0, exactly one low at a time
key_valid  out  1  buffer head holds an event
key_code  out  4  head event code
key_ready  in  1  consumer accepts head when key_valid&key_ready
key_held  out  1  debounced key currently down (PRESSED state)
key_overrun  out  1  one-cycle pulse when an event is dropped because the buffer is full

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - col_n=4'b0111 (column 0 strobed)
  - key_valid=0, key_code=0, key_held=0, key_overrun=0
  - buffer empty, FSM IDLE, all counters 0
- Key map, row-major, rows 0..3 × cols 0..3: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D. Codes are the hex values.
- Input path: row_n passes through a 2-FF synchroniser.
- Scan:
  - Column counter advances 0→1→2→3→0, with each column held SCAN_TICKS cycles.
  - Synchronised rows are sampled on the last cycle of each column's dwell.
  - One full scan = 4*SCAN_TICKS cycles.
- Scan result, evaluated after column 3 is sampled:
  - NONE if no press was seen.
  - CODE if exactly one press was seen.
  - MULTI if two or more were seen; MULTI is treated as NONE (ghost rejection).
- FSM, stepped once per scan end:
  - IDLE: CODE → DEBOUNCE with cand=code and cnt=1. If DEBOUNCE_SCANS=1, go straight to PRESSED and emit.
  - DEBOUNCE: result equal to cand → cnt+1; when cnt reaches DEBOUNCE_SCANS, emit cand and go to PRESSED. Any other result → IDLE.
  - PRESSED: key_held=1. A NONE/MULTI result increments rcnt and a CODE result clears it. At rcnt=DEBOUNCE_SCANS → IDLE. A different CODE does not emit; it must pass through IDLE first.
- Emit: pushes into the buffer on the cycle after the scan-end cycle.
- Buffer: 2-entry FIFO.
  - Head appears on key_code with key_valid=1 the cycle after the push.
  - key_code/key_valid stay stable until accepted.
  - Push while full: event dropped, key_overrun=1 for one cycle.
  - Push and pop in the same cycle while full: the pop happens first and the push is accepted.
- Reset mid-operation: asynchronous return to reset values; all buffered events are lost.
- Scanning runs continuously regardless of key_ready.

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- Defined: in PRESSED, a scan counter re-emits cand after REPEAT_DELAY_SCANS scans, then every REPEAT_RATE_SCANS scans, while the key stays held. The counter is cleared on entry to PRESSED. Repeats obey the same overrun rule.
- Undefined: exactly one event per press; the REPEAT_* parameters are ignored.

Test Plan:
All scenarios use SCAN_TICKS=4 and DEBOUNCE_SCANS=2, so one scan = 16 cycles. The bench keypad model pulls row_n[3-r] low whenever col_n[3-c]=0.
- Reset: hold rst_n=0 for 5 cycles → col_n=0111, key_valid=0. After release, col_n follows 0111→1011→1101→1110, 4 cycles each.
- Single press '1' (r0,c0) held for 3 scans, key_ready=1 → exactly one key_valid pulse with key_code=4'h1, about 2 scans after press start. Release for 3 scans → key_held falls.
- Full map: press (3,2) → 4'hE, (3,1) → 4'hF, (1,3) → 4'hB, (3,0) → 4'h0. One event each, in order.
- Bounce and ghost:
  - Key '5' toggled every scan for 6 scans → no event.
  - Keys (0,0) and (2,2) held together → no event, key_held=0.
- Backpressure: key_ready=0; press 7, 8, 9 in turn → codes 7 and 8 stay buffered and key_overrun pulses once on the push of 9. Raise key_ready → accepts 7 then 8, then key_valid=0.
- Reset mid-debounce: assert rst_n low during the second scan of a press of 'A' → no event. Outputs are at reset values within the same cycle.
